// File: rtl/sid_audio_pkg.sv
// Shared widths, stereo sample pair type and output saturation helper.
package sid_audio_pkg;

  localparam int IN_W  = 18;
  localparam int OUT_W = 16;
  // Averaged sample after the worst-case gain shift of 3
  localparam int SH_W  = IN_W + 3;

  typedef struct packed {
    logic signed [OUT_W-1:0] l;
    logic signed [OUT_W-1:0] r;
  } sample_pair_t;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] val;
  } sat_res_t;

  // Clamp a full-width scaled sample into the signed OUT_W range.
  // In range iff every bit from the MSB down to bit OUT_W-1 matches the sign.
  function automatic sat_res_t saturate_out(input logic signed [SH_W-1:0] v);
    sat_res_t             r;
    logic [SH_W-OUT_W:0]  hi_bits;
    hi_bits = v[SH_W-1:OUT_W-1];
    r.sat   = !((hi_bits == '0) || (hi_bits == '1));
    if (r.sat) begin
      r.val = v[SH_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      r.val = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sid_sample_fifo.sv
// Synchronous stereo-pair FIFO with count-based full/empty flags.
module sid_sample_fifo
  import sid_audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  sample_pair_t wr_data,
  input  logic         rd_en,
  output sample_pair_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  sample_pair_t     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer/count update; a write into a full FIFO is taken only if a read frees a slot
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sid_audio_decim.sv
// SID stereo audio decimator: box-filter average over 2^WIN_LOG2 samples,
// gain/saturate stage, then an output FIFO with sticky overflow.
module sid_audio_decim
  import sid_audio_pkg::*;
#(
  parameter int WIN_LOG2   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce_1m,
  input  logic signed [IN_W-1:0]  audio_l,
  input  logic signed [IN_W-1:0]  audio_r,
  input  logic [1:0]              gain,
  input  logic                    mute,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_l,
  output logic signed [OUT_W-1:0] out_r,
  output logic                    clip,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int ACC_W = IN_W + WIN_LOG2;

  // Stage 1: accumulation
  logic [ACC_W-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [ACC_W-1:0]       sum_l, sum_r;
  logic [WIN_LOG2-1:0]    cnt_q, cnt_d;
  logic signed [IN_W-1:0] avg_l_q, avg_l_d, avg_r_q, avg_r_d;
  logic                   avg_vld_q, avg_vld_d;

  // Stage 2: gain and saturation
  logic signed [SH_W-1:0] scl_l, scl_r;
  sat_res_t               sat_l, sat_r;
  sample_pair_t           res_q, res_d;
  logic                   push_q, push_d;
  logic                   clip_q, clip_d;

  // Output side
  sample_pair_t           fifo_rd_data;
  logic                   fifo_full, fifo_empty, pop;
  logic                   overflow_q, overflow_d;

  // Window accumulation; the closing sample is folded into the average directly
  always_comb begin
    sum_l     = acc_l_q + {{WIN_LOG2{audio_l[IN_W-1]}}, audio_l};
    sum_r     = acc_r_q + {{WIN_LOG2{audio_r[IN_W-1]}}, audio_r};
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    cnt_d     = cnt_q;
    avg_l_d   = avg_l_q;
    avg_r_d   = avg_r_q;
    avg_vld_d = 1'b0;
    if (ce_1m) begin
      if (cnt_q == '1) begin
        avg_l_d   = sum_l[ACC_W-1:WIN_LOG2];
        avg_r_d   = sum_r[ACC_W-1:WIN_LOG2];
        avg_vld_d = 1'b1;
        acc_l_d   = '0;
        acc_r_d   = '0;
        cnt_d     = '0;
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        cnt_d   = cnt_q + WIN_LOG2'(1);
      end
    end
  end

  // Scale by 2^gain / 4 with floor rounding, then clamp or mute
  always_comb begin
    scl_l  = {{3{avg_l_q[IN_W-1]}}, avg_l_q};
    scl_r  = {{3{avg_r_q[IN_W-1]}}, avg_r_q};
    scl_l  = scl_l <<< gain;
    scl_r  = scl_r <<< gain;
    scl_l  = scl_l >>> 2;
    scl_r  = scl_r >>> 2;
    sat_l  = saturate_out(scl_l);
    sat_r  = saturate_out(scl_r);
    res_d  = res_q;
    push_d = avg_vld_q;
    clip_d = 1'b0;
    if (avg_vld_q) begin
      if (mute) begin
        res_d = '0;
      end else begin
        res_d.l = sat_l.val;
        res_d.r = sat_r.val;
        clip_d  = sat_l.sat || sat_r.sat;
      end
    end
  end

  // Sticky overflow: a push is lost only when full and not popped this cycle; set wins over clear
  always_comb begin
    pop        = !fifo_empty && out_ready;
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (push_q && fifo_full && !pop) overflow_d = 1'b1;
  end

  // Pipeline and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      cnt_q      <= '0;
      avg_l_q    <= '0;
      avg_r_q    <= '0;
      avg_vld_q  <= 1'b0;
      res_q      <= '0;
      push_q     <= 1'b0;
      clip_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      cnt_q      <= cnt_d;
      avg_l_q    <= avg_l_d;
      avg_r_q    <= avg_r_d;
      avg_vld_q  <= avg_vld_d;
      res_q      <= res_d;
      push_q     <= push_d;
      clip_q     <= clip_d;
      overflow_q <= overflow_d;
    end
  end

  sid_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_q),
    .wr_data (res_q),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_l     = fifo_empty ? '0 : fifo_rd_data.l;
  assign out_r     = fifo_empty ? '0 : fifo_rd_data.r;
  assign clip      = clip_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sid_audio_decim.sv
// Directed testbench for sid_audio_decim with hand-computed expectations.
module tb_sid_audio_decim;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce_1m;
  logic signed [17:0] audio_l, audio_r;
  logic [1:0]         gain;
  logic               mute;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_l, out_r;
  logic               clip;
  logic               overflow;
  logic               clr_overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sid_audio_decim #(
    .WIN_LOG2   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce_1m        (ce_1m),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .gain         (gain),
    .mute         (mute),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_l        (out_l),
    .out_r        (out_r),
    .clip         (clip),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int l, input int r, input int n);
    for (int i = 0; i < n; i++) begin
      ce_1m   = 1'b1;
      audio_l = 18'(l);
      audio_r = 18'(r);
      step();
    end
    ce_1m = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_1m = 1'b0; audio_l = '0; audio_r = '0;
    gain = 2'd0; mute = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_l", out_l, 0);
    check_eq("rst_r", out_r, 0);
    check_eq("rst_clip", clip, 0);
    check_eq("rst_ovf", overflow, 0);

    // Constant 4096, gain 0 -> 1024, valid 3 cycles after last ce
    feed(4096, 4096, 16);
    check_eq("t1_valid_t1", out_valid, 0);
    step();
    check_eq("t1_valid_t2", out_valid, 0);
    check_eq("t1_clip", clip, 0);
    step();
    check_eq("t1_valid_t3", out_valid, 1);
    check_eq("t1_l", out_l, 1024);
    check_eq("t1_r", out_r, 1024);
    step();
    check_eq("t1_hold_l", out_l, 1024);
    check_eq("t1_hold_valid", out_valid, 1);
    pop_one();
    check_eq("t1_empty", out_valid, 0);
    check_eq("t1_empty_l", out_l, 0);

    // Saturation both ways with gain 3; clip is a single pulse
    gain = 2'd3;
    feed(131071, -131072, 16);
    step();
    check_eq("t2_clip_on", clip, 1);
    step();
    check_eq("t2_clip_off", clip, 0);
    check_eq("t2_l", out_l, 32767);
    check_eq("t2_r", out_r, -32768);
    pop_one();

    // Floor rounding: -5/4 -> -2, 7/4 -> 1
    gain = 2'd0;
    feed(-5, 7, 16);
    step(); step();
    check_eq("t3_floor_l", out_l, -2);
    check_eq("t3_floor_r", out_r, 1);
    pop_one();

    // Floor in averaging: avg(-1/16) = -1 -> -8>>2 = -2; avg(17/16) = 1 -> 8>>2 = 2
    gain = 2'd3;
    feed(0, 0, 15);
    feed(-1, 17, 1);
    step();
    check_eq("t4_clip", clip, 0);
    step();
    check_eq("t4_l", out_l, -2);
    check_eq("t4_r", out_r, 2);
    pop_one();

    // Overflow: five windows into a 4-deep FIFO without popping
    gain = 2'd0;
    for (int v = 1; v <= 5; v++) feed(4 * v, -4 * v, 16);
    step(); step(); step();
    check_eq("t5_ovf", overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      check_eq("t5_pop_valid", out_valid, 1);
      check_eq("t5_pop_l", out_l, k);
      check_eq("t5_pop_r", out_r, -k);
      pop_one();
    end
    check_eq("t5_drained", out_valid, 0);
    check_eq("t5_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check_eq("t5_ovf_clr", overflow, 0);

    // Reset mid-window discards the partial accumulation
    feed(400, 400, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    check_eq("t6_no_out", out_valid, 0);
    feed(400, 400, 16);
    step(); step();
    check_eq("t6_valid", out_valid, 1);
    check_eq("t6_l", out_l, 100);
    check_eq("t6_r", out_r, 100);
    pop_one();

    // Mute on a would-be saturating window
    mute = 1'b1;
    gain = 2'd3;
    feed(131071, -131072, 16);
    step();
    check_eq("t7_clip", clip, 0);
    step();
    check_eq("t7_valid", out_valid, 1);
    check_eq("t7_l", out_l, 0);
    check_eq("t7_r", out_r, 0);
    pop_one();
    check_eq("t7_empty", out_valid, 0);
    mute = 1'b0;

    // Full FIFO with push and pop in the same cycle
    gain = 2'd0;
    for (int v = 1; v <= 4; v++) feed(4 * v, 4 * v, 16);
    step(); step(); step();
    feed(20, 20, 16);
    step();
    out_ready = 1'b1;  // this cycle carries the push of value 5
    step();
    out_ready = 1'b0;
    check_eq("t8_ovf", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      check_eq("t8_pop_l", out_l, k);
      pop_one();
    end
    check_eq("t8_drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
